// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW reference path: controller state encoding and
// the default sample/address widths used by dtw_mem, the streamer and the core.
package dtw_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int PTR_WID_DEF = 18;

  typedef logic [1:0] dtw_state_t;

  localparam dtw_state_t S_IDLE   = 2'd0;
  localparam dtw_state_t S_LOAD   = 2'd1;
  localparam dtw_state_t S_STREAM = 2'd2;

endpackage

// File: rtl/dtw_skid_buf.sv
// Two-entry FIFO of {data, last} between the BRAM read port and the output
// stream; absorbs read latency so output backpressure never loses a sample.
module dtw_skid_buf
  import dtw_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last
);

  logic [WIDTH-1:0] data_q [2];
  logic [1:0]       last_q;
  logic             wr_idx;
  logic             rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= 2'd0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else begin
      if (push) wr_idx <= ~wr_idx;
      if (pop)  rd_idx <= ~rd_idx;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_idx] <= push_data;
      last_q[wr_idx] <= push_last;
    end
  end

  assign head_data = data_q[rd_idx];
  assign head_last = last_q[rd_idx];

endmodule

// File: rtl/dtw_ref_streamer.sv
// Owns the single dtw_mem port: sequential load from an input stream, then
// in-order read-back to the DTW core through a 2-entry skid buffer.
module dtw_ref_streamer
  import dtw_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PTR_WID = PTR_WID_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  input  logic               stream_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic [PTR_WID:0]   ref_len,
  output logic               mem_wen,
  output logic [PTR_WID-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_din,
  input  logic [WIDTH-1:0]   mem_dout
);

  dtw_state_t         state;
  dtw_state_t         state_nxt;
  logic [PTR_WID-1:0] wptr;
  logic [PTR_WID:0]   rptr;
  logic               rd_vld_p1;
  logic               rd_last_p1;
  logic [1:0]         occ;
  logic [WIDTH-1:0]   head_data;
  logic               head_last;

  logic go_load;
  logic go_stream;
  logic beat;
  logic load_end;
  logic strm_vld;
  logic pop;
  logic issue;
  logic stream_end;

  assign go_load   = (state == S_IDLE) && load_start;
  assign go_stream = (state == S_IDLE) && !load_start && stream_start &&
                     (ref_len != '0);
  assign beat      = (state == S_LOAD) && in_valid;
  assign load_end  = beat && (in_last || (&wptr));
  assign strm_vld  = (state == S_STREAM) && (occ != 2'd0);
  assign pop       = strm_vld && out_ready;
  // Issue only if the buffer still has room once the pending read lands.
  assign issue     = (state == S_STREAM) && (rptr < ref_len) &&
                     (({1'b0, occ} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop}));
  assign stream_end = pop && head_last;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go_load)        state_nxt = S_LOAD;
        else if (go_stream) state_nxt = S_STREAM;
      end
      S_LOAD:   if (load_end)   state_nxt = S_IDLE;
      S_STREAM: if (stream_end) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          mem_wen  = 1'b1;
          mem_addr = wptr;
          mem_din  = in_data;
        end
      end
      S_STREAM: begin
        busy      = 1'b1;
        out_valid = strm_vld;
        if (strm_vld) begin
          out_data = head_data;
          out_last = head_last;
        end
        if (issue) mem_addr = rptr[PTR_WID-1:0];
      end
      default: ;
    endcase
  end

  // Stage p1: read issued last cycle, its data is on mem_dout now.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      ref_len    <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && (rptr == (ref_len - 1'b1));
      if (go_load) begin
        wptr    <= '0;
        ref_len <= '0;
      end else if (beat) begin
        wptr <= wptr + 1'b1;
        if (load_end) ref_len <= {1'b0, wptr} + 1'b1;
      end
      if (go_stream)  rptr <= '0;
      else if (issue) rptr <= rptr + 1'b1;
    end
  end

  dtw_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_vld_p1),
    .push_data (mem_dout),
    .push_last (rd_last_p1),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data),
    .head_last (head_last)
  );

endmodule

// File: tb/tb_dtw_ref_streamer.sv
// Scoreboard bench for dtw_ref_streamer at reduced depth (8 entries) with a
// behavioural BRAM and a sample-list reference model.
module tb_dtw_ref_streamer;

  localparam int W     = 16;
  localparam int PW    = 3;
  localparam int DEPTH = 1 << PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          stream_start;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic [PW:0]   ref_len;
  logic          mem_wen;
  logic [PW-1:0] mem_addr;
  logic [W-1:0]  mem_din;
  logic [W-1:0]  mem_dout;

  dtw_ref_streamer #(.WIDTH(W), .PTR_WID(PW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .stream_start(stream_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ref_len(ref_len),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [W-1:0] bmem [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) bmem[mem_addr] <= mem_din;
    mem_dout <= bmem[mem_addr];
  end

  typedef struct { logic [PW-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { logic [W-1:0] data; logic last; } out_t;

  wr_t          exp_wr[$];
  out_t         exp_out[$];
  logic [W-1:0] model_ref [DEPTH];
  int           model_len = 0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           hs_cnt = 0;
  int           rdy_mode = 0;
  logic [5:0]   tog_pat = 6'b101001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = tog_pat[cyc % 6];
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin : monitor
    wr_t w;
    if (!rst) begin
      if (mem_wen) begin
        if (exp_wr.size() == 0) flag("unexpected_write");
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", 32'(mem_din), 32'(w.data));
        end
      end
      if (out_valid) begin
        if (exp_out.size() == 0) flag("unexpected_out_valid");
        else begin
          chk("out_data", 32'(out_data), 32'(exp_out[0].data));
          chk("out_last", 32'(out_last), 32'(exp_out[0].last));
          if (out_ready) begin
            void'(exp_out.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"},  32'(in_ready),  0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"},  32'(out_last),  0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_ref_len"},   32'(ref_len),   0);
    chk({tag, "_mem_wen"},   32'(mem_wen),   0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  0);
    chk({tag, "_mem_din"},   32'(mem_din),   0);
    @(posedge clk); #1;
  endtask

  task automatic ignored_stream();
    stream_start = 1'b1;
    @(posedge clk); #1;
    stream_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ignored_start_busy", 32'(busy), 0);
      chk("ignored_start_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input int n, input int last_at, input bit both, input int base);
    logic [W-1:0] samp [$];
    int acc;
    wr_t w;
    for (int i = 0; i < n; i++)
      samp.push_back((base >= 0) ? W'(base + i) : W'($urandom));
    acc = (last_at >= 0) ? last_at + 1 : n;
    if (acc > DEPTH) acc = DEPTH;
    for (int i = 0; i < acc; i++) begin
      w.addr = PW'(i);
      w.data = samp[i];
      exp_wr.push_back(w);
      model_ref[i] = samp[i];
    end
    model_len = acc;
    load_start   = 1'b1;
    stream_start = both;
    @(posedge clk); #1;
    load_start   = 1'b0;
    stream_start = 1'b0;
    for (int i = 0; i < acc; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = samp[i];
      in_last  = (i == last_at);
      @(negedge clk);
      chk("load_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("load_done_busy", 32'(busy), 0);
    chk("load_ref_len", 32'(ref_len), 32'(acc));
    chk("load_done_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    for (int i = acc; i < n && i < acc + 3; i++) begin
      in_valid = 1'b1;
      in_data  = samp[i];
      @(negedge clk);
      chk("extra_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("writes_drained", 32'(exp_wr.size()), 0);
  endtask

  task automatic do_stream(input int mode);
    int c0;
    int len;
    bit done;
    out_t e;
    len = model_len;
    rdy_mode = mode;
    for (int i = 0; i < len; i++) begin
      e.data = model_ref[i];
      e.last = (i == len - 1);
      exp_out.push_back(e);
    end
    stream_start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    stream_start = 1'b0;
    chk("stream_busy_rise", 32'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("first_valid_latency", 32'(out_valid), 32'(k == 3));
      if (k < 3) @(posedge clk);
    end
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      if (exp_out.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      flag("stream_timeout");
      exp_out.delete();
    end else if (mode == 0) begin
      chk("stream_cycles", 32'(cyc - c0), 32'(len + 3));
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; stream_start = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");
    ignored_stream();

    do_load(5, 4, 1'b0, 'h11);
    do_stream(0);
    do_stream(1);

    do_load(10, -1, 1'b1, -1);
    do_stream(2);

    for (int it = 0; it < 14; it++) begin
      int n;
      int la;
      n  = $urandom_range(1, 10);
      la = $urandom_range(0, n - 1);
      if (n >= DEPTH && $urandom_range(0, 1) == 1) la = -1;
      do_load(n, la, 1'b0, -1);
      do_stream($urandom_range(0, 2));
    end

    rdy_mode = 0;
    do_load(5, 4, 1'b0, 'h40);
    begin
      int hs0;
      out_t e;
      for (int i = 0; i < model_len; i++) begin
        e.data = model_ref[i];
        e.last = (i == model_len - 1);
        exp_out.push_back(e);
      end
      hs0 = hs_cnt;
      stream_start = 1'b1;
      @(posedge clk); #1;
      stream_start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_out.delete();
      chk("beats_before_rst", 32'(hs_cnt - hs0), 2);
    end
    check_zero("mid_stream_rst");
    ignored_stream();

    do_load(6, 5, 1'b0, -1);
    do_stream(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
